// File: rtl/psram_usr_arb.sv
// Round-robin arbiter sharing one PSRAM user-side datapath between NUM_PORT requesters.
// A grant covers a whole burst and is released after exactly len+1 beats.
module psram_usr_arb #(
  parameter int NUM_PORT = 2,
  parameter int ADDR_W   = 23,
  parameter int DATA_W   = 64,
  localparam int STRB_W  = DATA_W / 8,
  localparam int IDX_W   = $clog2(NUM_PORT)
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [NUM_PORT-1:0]        req_i,
  input  logic [NUM_PORT-1:0]        req_wen_i,
  input  logic [NUM_PORT*8-1:0]      req_len_i,
  input  logic [NUM_PORT-1:0]        req_xfer_start_i,
  input  logic [NUM_PORT*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_PORT*STRB_W-1:0] req_bm_i,
  input  logic [NUM_PORT*DATA_W-1:0] req_dat_i,
  output logic [NUM_PORT-1:0]        gnt_o,
  output logic [NUM_PORT-1:0]        req_wready_o,
  output logic [NUM_PORT-1:0]        req_rvalid_o,
  output logic [DATA_W-1:0]          req_dat_o,
  output logic                       usr_xfer_start_o,
  output logic                       usr_wen_o,
  output logic [7:0]                 usr_wlen_o,
  output logic [ADDR_W-1:0]          usr_addr_o,
  output logic [STRB_W-1:0]          usr_bm_o,
  output logic [DATA_W-1:0]          usr_dat_o,
  input  logic [DATA_W-1:0]          usr_dat_i,
  input  logic                       usr_wready_i,
  input  logic                       usr_rvalid_i
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] owner_reg, owner_next;
  logic [IDX_W-1:0] last_reg, last_next;
  logic             wen_reg, wen_next;
  logic [7:0]       len_reg, len_next;
  logic [7:0]       cnt_reg, cnt_next;
  logic [IDX_W-1:0] win_idx;
  logic             busy;
  logic             beat;

  // First requesting port strictly after the last served one, wrapping around.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_PORT-1:0] req,
                                               input logic [IDX_W-1:0]    last);
    logic [IDX_W-1:0] pick;
    logic             found;
    int               k;
    pick  = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_PORT; i++) begin
      k = int'(last) + i;
      if (k >= NUM_PORT) k = k - NUM_PORT;
      if (!found && req[k]) begin
        pick  = k[IDX_W-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign win_idx   = rr_pick(req_i, last_reg);
  assign busy      = (state_reg == BUSY);
  assign beat      = wen_reg ? usr_wready_i : usr_rvalid_i;
  assign req_dat_o = usr_dat_i;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORT; gi++) begin : g_port
      assign gnt_o[gi]        = busy && (owner_reg == IDX_W'(gi));
      assign req_wready_o[gi] = gnt_o[gi] & usr_wready_i;
      assign req_rvalid_o[gi] = gnt_o[gi] & usr_rvalid_i;
    end
  endgenerate

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg <= IDLE;
      owner_reg <= '0;
      last_reg  <= IDX_W'(NUM_PORT - 1);
      wen_reg   <= 1'b0;
      len_reg   <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      last_reg  <= last_next;
      wen_reg   <= wen_next;
      len_reg   <= len_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    owner_next       = owner_reg;
    last_next        = last_reg;
    wen_next         = wen_reg;
    len_next         = len_reg;
    cnt_next         = cnt_reg;
    usr_xfer_start_o = 1'b0;
    usr_wen_o        = 1'b0;
    usr_wlen_o       = '0;
    usr_addr_o       = '0;
    usr_bm_o         = '0;
    usr_dat_o        = '0;
    case (state_reg)
      IDLE: begin
        if (|req_i) begin
          owner_next = win_idx;
          wen_next   = req_wen_i[win_idx];
          len_next   = req_len_i[win_idx*8 +: 8];
          cnt_next   = '0;
          state_next = BUSY;
        end
      end
      BUSY: begin
        usr_xfer_start_o = req_xfer_start_i[owner_reg];
        usr_wen_o        = wen_reg;
        usr_wlen_o       = wen_reg ? len_reg : 8'd0;
        usr_addr_o       = req_addr_i[owner_reg*ADDR_W +: ADDR_W];
        usr_bm_o         = req_bm_i[owner_reg*STRB_W +: STRB_W];
        usr_dat_o        = req_dat_i[owner_reg*DATA_W +: DATA_W];
        // 8-bit equality covers len=255 without a wider counter.
        if (beat) begin
          if (cnt_reg == len_reg) begin
            last_next  = owner_reg;
            state_next = IDLE;
          end else begin
            cnt_next = cnt_reg + 8'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_psram_usr_arb.sv
// Directed self-checking bench for psram_usr_arb with two requesters; the bench plays the PSRAM core.
module tb_psram_usr_arb;
  localparam int NP = 2;
  localparam int AW = 23;
  localparam int DW = 64;
  localparam int SW = DW / 8;

  logic             aclk = 1'b0;
  logic             aresetn = 1'b0;
  logic [NP-1:0]    req_i, req_wen_i, req_xfer_start_i;
  logic [NP*8-1:0]  req_len_i;
  logic [NP*AW-1:0] req_addr_i;
  logic [NP*SW-1:0] req_bm_i;
  logic [NP*DW-1:0] req_dat_i;
  logic [NP-1:0]    gnt_o, req_wready_o, req_rvalid_o;
  logic [DW-1:0]    req_dat_o, usr_dat_o, usr_dat_i;
  logic             usr_xfer_start_o, usr_wen_o, usr_wready_i, usr_rvalid_i;
  logic [7:0]       usr_wlen_o;
  logic [AW-1:0]    usr_addr_o;
  logic [SW-1:0]    usr_bm_o;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  psram_usr_arb #(.NUM_PORT(NP), .ADDR_W(AW), .DATA_W(DW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_i(req_i), .req_wen_i(req_wen_i), .req_len_i(req_len_i),
    .req_xfer_start_i(req_xfer_start_i), .req_addr_i(req_addr_i),
    .req_bm_i(req_bm_i), .req_dat_i(req_dat_i),
    .gnt_o(gnt_o), .req_wready_o(req_wready_o), .req_rvalid_o(req_rvalid_o),
    .req_dat_o(req_dat_o), .usr_xfer_start_o(usr_xfer_start_o), .usr_wen_o(usr_wen_o),
    .usr_wlen_o(usr_wlen_o), .usr_addr_o(usr_addr_o), .usr_bm_o(usr_bm_o),
    .usr_dat_o(usr_dat_o), .usr_dat_i(usr_dat_i),
    .usr_wready_i(usr_wready_i), .usr_rvalid_i(usr_rvalid_i)
  );

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic test_reset;
    req_i = '0; req_wen_i = '0; req_xfer_start_i = '0; req_len_i = '0;
    req_addr_i = {23'h0AAAAA, 23'h012345};
    req_bm_i   = {8'h0F, 8'hF0};
    req_dat_i  = {64'h2222_3333_4444_5555, 64'h1111_AAAA_BBBB_CCCC};
    usr_dat_i = 64'h0123_4567_89AB_CDEF; usr_wready_i = 1'b0; usr_rvalid_i = 1'b0;
    aresetn = 1'b0;
    #3;
    checks++; if (gnt_o !== 2'b00) begin errors++; $display("FAIL rst_gnt: got %b want 00", gnt_o); end
    checks++; if (usr_wen_o !== 1'b0 || usr_xfer_start_o !== 1'b0 || usr_wlen_o !== 8'd0) begin
      errors++; $display("FAIL rst_usr_ctl: wen=%b xs=%b wlen=%0d want 0 0 0", usr_wen_o, usr_xfer_start_o, usr_wlen_o); end
    checks++; if (usr_addr_o !== 23'd0 || usr_bm_o !== 8'd0 || usr_dat_o !== 64'd0) begin
      errors++; $display("FAIL rst_usr_data: addr=%h bm=%h dat=%h want 0", usr_addr_o, usr_bm_o, usr_dat_o); end
    checks++; if (req_wready_o !== 2'b00 || req_rvalid_o !== 2'b00) begin
      errors++; $display("FAIL rst_route: wready=%b rvalid=%b want 00 00", req_wready_o, req_rvalid_o); end
    checks++; if (req_dat_o !== 64'h0123_4567_89AB_CDEF) begin
      errors++; $display("FAIL rst_rdat: got %h want 0123456789abcdef", req_dat_o); end
    tick; tick;
    aresetn = 1'b1;
    tick;
    checks++; if (gnt_o !== 2'b00) begin errors++; $display("FAIL idle_gnt: got %b want 00", gnt_o); end
    $display("reset: done");
  endtask

  task automatic test_single_write;
    logic [1:0] exp;
    req_wen_i = 2'b01; req_len_i = {8'd7, 8'd3}; req_i = 2'b01;
    tick;
    checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL wr_gnt: got %b want 01", gnt_o); end
    checks++; if (usr_wen_o !== 1'b1 || usr_wlen_o !== 8'd3) begin
      errors++; $display("FAIL wr_ctl: wen=%b wlen=%0d want 1 3", usr_wen_o, usr_wlen_o); end
    checks++; if (usr_addr_o !== 23'h012345 || usr_bm_o !== 8'hF0 || usr_dat_o !== 64'h1111_AAAA_BBBB_CCCC) begin
      errors++; $display("FAIL wr_mux: addr=%h bm=%h dat=%h", usr_addr_o, usr_bm_o, usr_dat_o); end
    req_i = 2'b00;
    req_xfer_start_i = 2'b10; #1;
    checks++; if (usr_xfer_start_o !== 1'b0) begin errors++; $display("FAIL wr_xs_other: got %b want 0", usr_xfer_start_o); end
    req_xfer_start_i = 2'b01; #1;
    checks++; if (usr_xfer_start_o !== 1'b1) begin errors++; $display("FAIL wr_xs_owner: got %b want 1", usr_xfer_start_o); end
    req_xfer_start_i = 2'b00;
    for (int b = 0; b < 4; b++) begin
      usr_wready_i = 1'b1; #1;
      checks++; if (req_wready_o !== 2'b01) begin errors++; $display("FAIL wr_wready b%0d: got %b want 01", b, req_wready_o); end
      tick;
      usr_wready_i = 1'b0;
      exp = (b == 3) ? 2'b00 : 2'b01;
      checks++; if (gnt_o !== exp) begin errors++; $display("FAIL wr_hold b%0d: got %b want %b", b, gnt_o, exp); end
    end
    checks++; if (usr_wen_o !== 1'b0 || usr_wlen_o !== 8'd0) begin
      errors++; $display("FAIL wr_idle_ctl: wen=%b wlen=%0d want 0 0", usr_wen_o, usr_wlen_o); end
    $display("burst: port0 write len=3 4 beats");
  endtask

  task automatic test_simultaneous;
    aresetn = 1'b0; #1; aresetn = 1'b1;
    req_wen_i = 2'b11; req_len_i = {8'd0, 8'd1}; req_i = 2'b11;
    tick;
    checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL sim_first: got %b want 01", gnt_o); end
    req_i = 2'b10;
    for (int b = 0; b < 2; b++) begin
      usr_wready_i = 1'b1; #1;
      checks++; if (req_wready_o !== 2'b01) begin errors++; $display("FAIL sim_route0 b%0d: got %b want 01", b, req_wready_o); end
      tick;
      usr_wready_i = 1'b0;
    end
    checks++; if (gnt_o !== 2'b00) begin errors++; $display("FAIL sim_bubble: got %b want 00", gnt_o); end
    tick;
    checks++; if (gnt_o !== 2'b10) begin errors++; $display("FAIL sim_second: got %b want 10", gnt_o); end
    req_i = 2'b01;
    usr_wready_i = 1'b1; #1;
    checks++; if (req_wready_o !== 2'b10) begin errors++; $display("FAIL sim_route1: got %b want 10", req_wready_o); end
    tick;
    usr_wready_i = 1'b0;
    checks++; if (gnt_o !== 2'b00) begin errors++; $display("FAIL sim_rel1: got %b want 00", gnt_o); end
    tick;
    checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL sim_third: got %b want 01", gnt_o); end
    req_i = 2'b00;
    usr_wready_i = 1'b1; tick; tick;
    usr_wready_i = 1'b0;
    checks++; if (gnt_o !== 2'b00) begin errors++; $display("FAIL sim_rel0: got %b want 00", gnt_o); end
    $display("burst: port0, port1, port0 rotation");
  endtask

  task automatic test_read_len0;
    req_wen_i = 2'b00; req_len_i = {8'd0, 8'd0}; req_i = 2'b10;
    tick;
    checks++; if (gnt_o !== 2'b10 || usr_wen_o !== 1'b0) begin
      errors++; $display("FAIL rd_gnt: gnt=%b wen=%b want 10 0", gnt_o, usr_wen_o); end
    req_i = 2'b00;
    usr_rvalid_i = 1'b1; usr_dat_i = 64'hDEADBEEF_CAFEF00D; #1;
    checks++; if (req_rvalid_o !== 2'b10) begin errors++; $display("FAIL rd_route: got %b want 10", req_rvalid_o); end
    checks++; if (req_dat_o !== 64'hDEADBEEF_CAFEF00D) begin errors++; $display("FAIL rd_data: got %h want deadbeefcafef00d", req_dat_o); end
    tick;
    usr_rvalid_i = 1'b0;
    checks++; if (gnt_o !== 2'b00 || req_rvalid_o !== 2'b00) begin
      errors++; $display("FAIL rd_rel: gnt=%b rvalid=%b want 00 00", gnt_o, req_rvalid_o); end
    $display("burst: port1 read len=0 1 beat");
  endtask

  task automatic test_long_burst;
    logic [1:0] exp;
    req_wen_i = 2'b01; req_len_i = {8'd0, 8'd255}; req_i = 2'b01;
    tick;
    checks++; if (gnt_o !== 2'b01 || usr_wlen_o !== 8'd255) begin
      errors++; $display("FAIL long_gnt: gnt=%b wlen=%0d want 01 255", gnt_o, usr_wlen_o); end
    req_i = 2'b00;
    for (int b = 0; b < 256; b++) begin
      if (b % 4 == 0) begin
        usr_rvalid_i = 1'b1; usr_wready_i = 1'b0;
        tick;
        checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL long_noise b%0d: got %b want 01", b, gnt_o); end
      end
      usr_wready_i = 1'b1; usr_rvalid_i = 1'($urandom_range(0, 1));
      tick;
      usr_wready_i = 1'b0; usr_rvalid_i = 1'b0;
      exp = (b == 255) ? 2'b00 : 2'b01;
      checks++; if (gnt_o !== exp) begin errors++; $display("FAIL long_hold b%0d: got %b want %b", b, gnt_o, exp); end
    end
    $display("burst: port0 write len=255 256 beats with rvalid noise");
  endtask

  task automatic test_owner_drop;
    logic [1:0] exp;
    req_wen_i = 2'b00; req_len_i = {8'd0, 8'd2}; req_i = 2'b01;
    tick;
    checks++; if (gnt_o !== 2'b01 || usr_wlen_o !== 8'd0 || usr_wen_o !== 1'b0) begin
      errors++; $display("FAIL drop_gnt: gnt=%b wlen=%0d wen=%b want 01 0 0", gnt_o, usr_wlen_o, usr_wen_o); end
    usr_rvalid_i = 1'b1; #1;
    checks++; if (req_rvalid_o !== 2'b01) begin errors++; $display("FAIL drop_route: got %b want 01", req_rvalid_o); end
    tick;
    req_i = 2'b10; req_wen_i = 2'b10;
    for (int b = 1; b < 3; b++) begin
      usr_rvalid_i = 1'b1; usr_wready_i = 1'b1; #1;
      checks++; if (req_wready_o[1] !== 1'b0 || req_rvalid_o[1] !== 1'b0 || gnt_o !== 2'b01) begin
        errors++; $display("FAIL drop_leak b%0d: gnt=%b wready=%b rvalid=%b want 01 x0 x0", b, gnt_o, req_wready_o, req_rvalid_o); end
      tick;
      usr_rvalid_i = 1'b0; usr_wready_i = 1'b0;
      exp = (b == 2) ? 2'b00 : 2'b01;
      checks++; if (gnt_o !== exp) begin errors++; $display("FAIL drop_hold b%0d: got %b want %b", b, gnt_o, exp); end
    end
    tick;
    checks++; if (gnt_o !== 2'b10) begin errors++; $display("FAIL drop_next: got %b want 10", gnt_o); end
    req_i = 2'b00;
    usr_wready_i = 1'b1; tick;
    usr_wready_i = 1'b0;
    checks++; if (gnt_o !== 2'b00) begin errors++; $display("FAIL drop_rel1: got %b want 00", gnt_o); end
    $display("burst: port0 read len=2 with drop, then port1 write len=0");
  endtask

  task automatic test_reset_midburst;
    req_wen_i = 2'b11; req_len_i = {8'd3, 8'd0}; req_i = 2'b01;
    tick;
    req_i = 2'b00;
    usr_wready_i = 1'b1; tick;
    usr_wready_i = 1'b0;
    req_i = 2'b10;
    tick;
    checks++; if (gnt_o !== 2'b10) begin errors++; $display("FAIL rmb_gnt: got %b want 10", gnt_o); end
    req_i = 2'b00;
    usr_wready_i = 1'b1; tick;
    req_xfer_start_i = 2'b10; #1;
    checks++; if (usr_xfer_start_o !== 1'b1) begin errors++; $display("FAIL rmb_xs: got %b want 1", usr_xfer_start_o); end
    aresetn = 1'b0; #1;
    checks++; if (gnt_o !== 2'b00 || usr_wen_o !== 1'b0 || usr_xfer_start_o !== 1'b0 || req_wready_o !== 2'b00) begin
      errors++; $display("FAIL rmb_async: gnt=%b wen=%b xs=%b wready=%b want 00 0 0 00", gnt_o, usr_wen_o, usr_xfer_start_o, req_wready_o); end
    usr_wready_i = 1'b0; req_xfer_start_i = 2'b00;
    req_len_i = {8'd0, 8'd0}; req_i = 2'b11;
    tick;
    checks++; if (gnt_o !== 2'b00) begin errors++; $display("FAIL rmb_held: got %b want 00", gnt_o); end
    aresetn = 1'b1;
    tick;
    checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL rmb_prio: got %b want 01", gnt_o); end
    req_i = 2'b00;
    usr_wready_i = 1'b1; tick;
    usr_wready_i = 1'b0;
    $display("burst: port1 interrupted by reset, port0 served first after");
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_simultaneous();
    test_read_len0();
    test_long_burst();
    test_owner_drop();
    test_reset_midburst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
